ecc_serial_loader: RTL and testbench
====================================

// Module: ecc_serial_loader
// PURPOSE
// - Input stage ahead of the ECC point-multiply core. Deserialises the bit-serial host protocol
//   (mode header, then a/b/prime/Px/Py/m and nPx/nPy, MSB first) into parallel operand registers.
// - Issues one valid/ready operand bundle to the core when both channels are complete.
// PARAMETERS
// - MAX_BITS  256  operand register width; largest supported field size
// - CNT_W       9  bit-counter width; must hold MAX_BITS
// PORTS
// - clk          in   1         single clock; all logic on posedge
// - rst          in   1         synchronous, active-high reset
// - i_m_P_valid  in   1         one-cycle start pulse for the mP channel
// - i_mode       in   1         mode header bit, serial (mode[1] then mode[0])
// - i_a,i_b,i_prime,i_Px,i_Py,i_m  in  1 each  mP-channel serial data, MSB first
// - i_nP_valid   in   1         one-cycle start pulse for the nP channel
// - i_nPx,i_nPy  in   1 each    nP-channel serial data, MSB first
// - i_op_ready   in   1         core accepts the bundle
// - o_op_valid   out  1         bundle complete and stable
// - o_mode       out  2         latched mode
// - o_a,o_b,o_prime,o_Px,o_Py,o_m,o_nPx,o_nPy  out  MAX_BITS each  right-aligned operands
// - o_proto_err  out  1         sticky protocol-violation flag
// - o_range_err  out  1         point coordinate >= prime (ECC_LOADER_RANGE_CHECK_EN only)
// BEHAVIOUR
// - Reset: both FSMs IDLE; all operand regs, o_mode, counters 0; o_op_valid, o_proto_err, o_range_err 0; mode_known 0.
// - Length N from mode: 00->32, 01->64, 10->128, 11->256.
// - mP FSM: IDLE -> MODE_HI -> MODE_LO -> SHIFT -> DONE.
//   - i_m_P_valid sampled high at edge k in IDLE: go MODE_HI; clear a/b/prime/Px/Py/m.
//   - Edge k+1 latches i_mode into mode[1]; edge k+2 latches mode[0], sets mode_known, loads cnt=N.
//   - Edges k+3 .. k+2+N: each lane reg <= {reg[MAX_BITS-2:0], i_x}; cnt decrements; cnt==1 -> DONE.
//   - Upper MAX_BITS-N bits stay 0.
// - nP FSM: IDLE -> SHIFT -> DONE.
//   - i_nP_valid sampled high at edge j in IDLE with mode_known=1: go SHIFT; clear nPx/nPy; cnt=N.
//   - Edges j+1 .. j+N shift i_nPx/i_nPy; cnt==1 -> DONE.
//   - Same-edge start with the mode_known set-up (j = k+2) is a violation: mode_known is still 0.
// - o_op_valid = both FSMs in DONE; first rises the cycle after the later channel's last bit.
//   Operands and o_mode held constant while o_op_valid=1.
// - Handshake: o_op_valid & i_op_ready at an edge -> both FSMs IDLE, mode_known 0.
//   Operand regs keep their values until the next start.
// - Protocol errors: each of the following sets o_proto_err (sticky until rst) and the pulse is ignored, no state change:
//   - i_m_P_valid when the mP FSM is not IDLE
//   - i_nP_valid when the nP FSM is not IDLE
//   - i_nP_valid with mode_known=0
// - rst high mid-operation: return to reset state on that edge; partial data discarded; no o_op_valid.
// - Serial inputs are don't-care (may be X) outside their shift windows; never sampled there.
// CONFIGURATION
// - ECC_LOADER_RANGE_CHECK_EN defined:
//   - On entry to joint DONE, compare Px, Py, nPx, nPy against prime (unsigned, MAX_BITS wide).
//   - o_range_err <= 1 if any >= prime; valid with o_op_valid; cleared on handshake and rst.
//   - Bundle is still issued.
// - Not defined: no comparators; o_range_err tied 0.
// TESTING
// - Mode 00, nP start 10 cycles after mP start, a=32'h00000003, prime=32'hFFFFFFFB, m=32'h1234ABCD ->
//   o_op_valid rises 1 cycle after last nP bit; o_a==3, o_m==32'h1234ABCD, bits[255:32]==0, o_mode==2'b00.
// - Mode 11, all lanes 256'h8000...0001, i_op_ready low 5 cycles ->
//   o_op_valid held high 5 cycles, outputs stable; drops the cycle after ready; o_proto_err==0.
// - i_nP_valid 1 cycle after i_m_P_valid (mode unknown) -> o_proto_err=1, nP FSM stays IDLE;
//   retry after mode latched -> completes normally.
// - Second i_m_P_valid during mP SHIFT -> ignored; o_proto_err=1; captured operands unchanged.
// - rst pulsed at bit 40 of a mode-01 load -> all outputs 0 next cycle;
//   a fresh mode-01 load then completes correctly.
// - RANGE_CHECK_EN, mode 00, prime=32'h17, Px=32'h17 -> o_range_err=1 with o_op_valid;
//   Px=32'h16 -> o_range_err=0.

Source files
------------

// File: rtl/ecc_serial_loader.sv
// Bit-serial operand loader ahead of the ECC point-multiply core: mP and nP channels shift into
// parallel registers and are issued as one bundle. Define ECC_LOADER_RANGE_CHECK_EN for o_range_err.
//
// mP state | meaning
// IDLE     | waiting for i_m_P_valid
// MODE_HI  | capturing mode[1]
// MODE_LO  | capturing mode[0], loading bit counter
// SHIFT    | shifting a/b/prime/Px/Py/m
// DONE     | mP operands complete
//
// nP state | meaning
// IDLE     | waiting for i_nP_valid (needs mode_known)
// SHIFT    | shifting nPx/nPy
// DONE     | nP operands complete
module ecc_serial_loader #(
  parameter int MAX_BITS = 256,
  parameter int CNT_W    = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_m_P_valid,
  input  logic                i_mode,
  input  logic                i_a,
  input  logic                i_b,
  input  logic                i_prime,
  input  logic                i_Px,
  input  logic                i_Py,
  input  logic                i_m,
  input  logic                i_nP_valid,
  input  logic                i_nPx,
  input  logic                i_nPy,
  input  logic                i_op_ready,
  output logic                o_op_valid,
  output logic [1:0]          o_mode,
  output logic [MAX_BITS-1:0] o_a,
  output logic [MAX_BITS-1:0] o_b,
  output logic [MAX_BITS-1:0] o_prime,
  output logic [MAX_BITS-1:0] o_Px,
  output logic [MAX_BITS-1:0] o_Py,
  output logic [MAX_BITS-1:0] o_m,
  output logic [MAX_BITS-1:0] o_nPx,
  output logic [MAX_BITS-1:0] o_nPy,
  output logic                o_proto_err,
  output logic                o_range_err
);

  localparam int L_A     = 0;
  localparam int L_B     = 1;
  localparam int L_PRIME = 2;
  localparam int L_PX    = 3;
  localparam int L_PY    = 4;
  localparam int L_M     = 5;
  localparam int L_NPX   = 0;
  localparam int L_NPY   = 1;

  typedef enum logic [2:0] {
    MP_IDLE, MP_MODE_HI, MP_MODE_LO, MP_SHIFT, MP_DONE
  } mp_state_e;

  typedef enum logic [1:0] {
    NP_IDLE, NP_SHIFT, NP_DONE
  } np_state_e;

  mp_state_e                mp_state_q, mp_state_d;
  np_state_e                np_state_q, np_state_d;
  logic [5:0][MAX_BITS-1:0] mp_lane_q, mp_lane_d;
  logic [1:0][MAX_BITS-1:0] np_lane_q, np_lane_d;
  logic [CNT_W-1:0]         mp_cnt_q, mp_cnt_d;
  logic [CNT_W-1:0]         np_cnt_q, np_cnt_d;
  logic [1:0]               mode_q, mode_d;
  logic                     mode_known_q, mode_known_d;
  logic                     proto_err_q, proto_err_d;
  logic [5:0]               mp_bits;
  logic [1:0]               np_bits;
  logic                     mp_start, mp_err, np_start, np_err;
  logic                     handshake;

  function automatic logic [CNT_W-1:0] len_of(input logic [1:0] md);
    case (md)
      2'b00:   len_of = CNT_W'(32);
      2'b01:   len_of = CNT_W'(64);
      2'b10:   len_of = CNT_W'(128);
      default: len_of = CNT_W'(256);
    endcase
  endfunction

  assign mp_bits   = {i_m, i_Py, i_Px, i_prime, i_b, i_a};
  assign np_bits   = {i_nPy, i_nPx};
  assign handshake = o_op_valid & i_op_ready;

  // Pulses that arrive while a channel is busy, or before the mode is known, are dropped.
  assign mp_start = i_m_P_valid & (mp_state_q == MP_IDLE);
  assign mp_err   = i_m_P_valid & (mp_state_q != MP_IDLE);
  assign np_start = i_nP_valid & (np_state_q == NP_IDLE) & mode_known_q;
  assign np_err   = i_nP_valid & ~((np_state_q == NP_IDLE) & mode_known_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      mp_state_q   <= MP_IDLE;
      np_state_q   <= NP_IDLE;
      mp_lane_q    <= '0;
      np_lane_q    <= '0;
      mp_cnt_q     <= '0;
      np_cnt_q     <= '0;
      mode_q       <= '0;
      mode_known_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      mp_state_q   <= mp_state_d;
      np_state_q   <= np_state_d;
      mp_lane_q    <= mp_lane_d;
      np_lane_q    <= np_lane_d;
      mp_cnt_q     <= mp_cnt_d;
      np_cnt_q     <= np_cnt_d;
      mode_q       <= mode_d;
      mode_known_q <= mode_known_d;
      proto_err_q  <= proto_err_d;
    end
  end

  always_comb begin
    mp_state_d = mp_state_q;
    case (mp_state_q)
      MP_IDLE:    if (mp_start) mp_state_d = MP_MODE_HI;
      MP_MODE_HI: mp_state_d = MP_MODE_LO;
      MP_MODE_LO: mp_state_d = MP_SHIFT;
      MP_SHIFT:   if (mp_cnt_q == CNT_W'(1)) mp_state_d = MP_DONE;
      MP_DONE:    if (handshake) mp_state_d = MP_IDLE;
      default:    mp_state_d = MP_IDLE;
    endcase

    np_state_d = np_state_q;
    case (np_state_q)
      NP_IDLE:  if (np_start) np_state_d = NP_SHIFT;
      NP_SHIFT: if (np_cnt_q == CNT_W'(1)) np_state_d = NP_DONE;
      NP_DONE:  if (handshake) np_state_d = NP_IDLE;
      default:  np_state_d = NP_IDLE;
    endcase
  end

  always_comb begin
    mp_lane_d    = mp_lane_q;
    np_lane_d    = np_lane_q;
    mp_cnt_d     = mp_cnt_q;
    np_cnt_d     = np_cnt_q;
    mode_d       = mode_q;
    mode_known_d = mode_known_q;
    proto_err_d  = proto_err_q | mp_err | np_err;

    case (mp_state_q)
      MP_IDLE: if (mp_start) mp_lane_d = '0;
      MP_MODE_HI: mode_d[1] = i_mode;
      MP_MODE_LO: begin
        mode_d[0]    = i_mode;
        mode_known_d = 1'b1;
        mp_cnt_d     = len_of({mode_q[1], i_mode});
      end
      MP_SHIFT: begin
        for (int i = 0; i < 6; i++) begin
          mp_lane_d[i] = {mp_lane_q[i][MAX_BITS-2:0], mp_bits[i]};
        end
        mp_cnt_d = mp_cnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    case (np_state_q)
      NP_IDLE: if (np_start) begin
        np_lane_d = '0;
        np_cnt_d  = len_of(mode_q);
      end
      NP_SHIFT: begin
        for (int i = 0; i < 2; i++) begin
          np_lane_d[i] = {np_lane_q[i][MAX_BITS-2:0], np_bits[i]};
        end
        np_cnt_d = np_cnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    if (handshake) mode_known_d = 1'b0;
  end

  always_comb begin
    o_op_valid  = (mp_state_q == MP_DONE) && (np_state_q == NP_DONE);
    o_mode      = mode_q;
    o_a         = mp_lane_q[L_A];
    o_b         = mp_lane_q[L_B];
    o_prime     = mp_lane_q[L_PRIME];
    o_Px        = mp_lane_q[L_PX];
    o_Py        = mp_lane_q[L_PY];
    o_m         = mp_lane_q[L_M];
    o_nPx       = np_lane_q[L_NPX];
    o_nPy       = np_lane_q[L_NPY];
    o_proto_err = proto_err_q;
  end

`ifdef ECC_LOADER_RANGE_CHECK_EN
  logic range_err_q, range_err_d;
  logic enter_done, coord_ge;

  // Compare the next-state operands so the flag lands on the same edge as o_op_valid.
  always_comb begin
    enter_done  = (mp_state_d == MP_DONE) && (np_state_d == NP_DONE) && !o_op_valid;
    coord_ge    = (mp_lane_d[L_PX]  >= mp_lane_d[L_PRIME]) ||
                  (mp_lane_d[L_PY]  >= mp_lane_d[L_PRIME]) ||
                  (np_lane_d[L_NPX] >= mp_lane_d[L_PRIME]) ||
                  (np_lane_d[L_NPY] >= mp_lane_d[L_PRIME]);
    range_err_d = range_err_q;
    if (handshake)       range_err_d = 1'b0;
    else if (enter_done) range_err_d = coord_ge;
  end

  always_ff @(posedge clk) begin
    if (rst) range_err_q <= 1'b0;
    else     range_err_q <= range_err_d;
  end

  assign o_range_err = range_err_q;
`else
  assign o_range_err = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_serial_loader.sv
// Self-checking bench for ecc_serial_loader: directed and random serial loads against a
// bit-vector reference model (expected operands are the masked source values).
module tb_ecc_serial_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_m_P_valid, i_mode, i_a, i_b, i_prime, i_Px, i_Py, i_m;
  logic         i_nP_valid, i_nPx, i_nPy, i_op_ready;
  logic         o_op_valid, o_proto_err, o_range_err;
  logic [1:0]   o_mode;
  logic [255:0] o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy;

  // Reference operands: 0 a, 1 b, 2 prime, 3 Px, 4 Py, 5 m, 6 nPx, 7 nPy
  logic [255:0] v [8];
  logic [1:0]   vmode;
  logic         err_exp;
  int           n_cmp = 0;
  int           n_mis = 0;

  ecc_serial_loader dut (
    .clk(clk), .rst(rst),
    .i_m_P_valid(i_m_P_valid), .i_mode(i_mode),
    .i_a(i_a), .i_b(i_b), .i_prime(i_prime), .i_Px(i_Px), .i_Py(i_Py), .i_m(i_m),
    .i_nP_valid(i_nP_valid), .i_nPx(i_nPx), .i_nPy(i_nPy),
    .i_op_ready(i_op_ready), .o_op_valid(o_op_valid), .o_mode(o_mode),
    .o_a(o_a), .o_b(o_b), .o_prime(o_prime), .o_Px(o_Px), .o_Py(o_Py), .o_m(o_m),
    .o_nPx(o_nPx), .o_nPy(o_nPy), .o_proto_err(o_proto_err), .o_range_err(o_range_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic rng_exp();
`ifdef ECC_LOADER_RANGE_CHECK_EN
    return (v[3] >= v[2]) || (v[4] >= v[2]) || (v[6] >= v[2]) || (v[7] >= v[2]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    i_m_P_valid = 1'b0; i_nP_valid = 1'b0; i_mode = 1'bx;
    i_a = 1'bx; i_b = 1'bx; i_prime = 1'bx; i_Px = 1'bx; i_Py = 1'bx; i_m = 1'bx;
    i_nPx = 1'bx; i_nPy = 1'bx;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 8; w++) v[i][w*32 +: 32] = $urandom;
  endtask

  task automatic check_zero();
    chk1("rst_valid", o_op_valid, 1'b0);
    chkw("rst_mode", 256'(o_mode), 256'd0);
    chkw("rst_a", o_a, 256'd0);     chkw("rst_b", o_b, 256'd0);
    chkw("rst_prime", o_prime, 256'd0);
    chkw("rst_Px", o_Px, 256'd0);   chkw("rst_Py", o_Py, 256'd0);
    chkw("rst_m", o_m, 256'd0);
    chkw("rst_nPx", o_nPx, 256'd0); chkw("rst_nPy", o_nPy, 256'd0);
    chk1("rst_proto_err", o_proto_err, 1'b0);
    chk1("rst_range_err", o_range_err, 1'b0);
  endtask

  task automatic check_bundle();
    chkw("mode", 256'(o_mode), 256'(vmode));
    chkw("a", o_a, v[0]);       chkw("b", o_b, v[1]);
    chkw("prime", o_prime, v[2]);
    chkw("Px", o_Px, v[3]);     chkw("Py", o_Py, v[4]);
    chkw("m", o_m, v[5]);
    chkw("nPx", o_nPx, v[6]);   chkw("nPy", o_nPy, v[7]);
    chk1("proto_err", o_proto_err, err_exp);
    chk1("range_err", o_range_err, rng_exp());
  endtask

  // Serial load; cycle c drives the inputs sampled at edge c (edge 0 = mP start).
  task automatic load(input logic [1:0] md, input int np_off, input int extra_mp,
                      input int extra_np, input int rst_at);
    int n, last;
    logic [255:0] one, mask;
    n    = 32 << md;
    one  = 256'd1;
    mask = (one << n) - one;
    for (int i = 0; i < 8; i++) v[i] = v[i] & mask;
    vmode = md;
    last  = (np_off > 2) ? np_off + n : 2 + n;
    if (extra_mp >= 0 || extra_np >= 0) err_exp = 1'b1;
    for (int c = 0; c <= last; c++) begin
      i_m_P_valid = (c == 0) || (c == extra_mp);
      i_nP_valid  = (c == np_off) || (c == extra_np);
      i_mode      = (c == 1) ? md[1] : (c == 2) ? md[0] : 1'bx;
      if (c >= 3 && c <= 2 + n) begin
        i_a = v[0][n+2-c]; i_b = v[1][n+2-c]; i_prime = v[2][n+2-c];
        i_Px = v[3][n+2-c]; i_Py = v[4][n+2-c]; i_m = v[5][n+2-c];
      end else begin
        i_a = 1'bx; i_b = 1'bx; i_prime = 1'bx; i_Px = 1'bx; i_Py = 1'bx; i_m = 1'bx;
      end
      if (c > np_off && c <= np_off + n) begin
        i_nPx = v[6][np_off+n-c]; i_nPy = v[7][np_off+n-c];
      end else begin
        i_nPx = 1'bx; i_nPy = 1'bx;
      end
      if (c == rst_at) rst = 1'b1;
      tick();
      if (c == rst_at) begin
        rst = 1'b0;
        err_exp = 1'b0;
        idle_inputs();
        check_zero();
        return;
      end
      chk1("op_valid_timing", o_op_valid, c == last);
    end
    idle_inputs();
  endtask

  // Hold ready low, confirm stability, then handshake and confirm release.
  task automatic accept(input int nlow);
    i_op_ready = 1'b0;
    for (int k = 0; k < nlow; k++) begin
      tick();
      chk1("valid_held", o_op_valid, 1'b1);
      check_bundle();
    end
    i_op_ready = 1'b1;
    tick();
    i_op_ready = 1'b0;
    chk1("valid_drop", o_op_valid, 1'b0);
    chk1("range_err_clr", o_range_err, 1'b0);
    chkw("a_kept", o_a, v[0]);
    chkw("nPy_kept", o_nPy, v[7]);
  endtask

  initial begin
    rst = 1'b1; i_op_ready = 1'b0; err_exp = 1'b0; vmode = 2'b00;
    idle_inputs();
    tick(); tick(); tick();
    check_zero();
    rst = 1'b0;
    tick();
    check_zero();

    // Mode 00, nP starts 10 cycles after mP
    rand_lanes();
    v[0] = 256'h3; v[2] = 256'hFFFFFFFB; v[5] = 256'h1234ABCD;
    load(2'b00, 10, -1, -1, -1);
    check_bundle();
    accept(2);

    // Mode 11, all lanes 8000...0001, ready low for 5 cycles
    for (int i = 0; i < 8; i++) begin
      v[i] = 256'd1;
      v[i][255] = 1'b1;
    end
    load(2'b11, 5, -1, -1, -1);
    check_bundle();
    accept(5);

    // Random modes and channel offsets, including nP starting after mP finishes
    for (int t = 0; t < 6; t++) begin
      logic [1:0] md;
      md = 2'($urandom_range(0, 3));
      rand_lanes();
      load(md, (t == 0) ? 3 : int'($urandom_range(3, (32 << md) + 20)), -1, -1, -1);
      check_bundle();
      accept(t % 3);
    end

    // nP pulse before the mode is known, then proper start
    rand_lanes();
    load(2'b00, 8, -1, 1, -1);
    check_bundle();
    accept(1);

    // Second mP pulse during shift
    rand_lanes();
    load(2'b01, 6, 20, -1, -1);
    check_bundle();
    accept(1);

    // Extra nP pulse while nP is shifting
    rand_lanes();
    load(2'b00, 4, -1, 10, -1);
    check_bundle();
    accept(0);

    // Reset at bit 40 of a mode-01 load, then a fresh load
    rand_lanes();
    load(2'b01, 5, -1, -1, 43);
    rand_lanes();
    load(2'b01, 5, -1, -1, -1);
    check_bundle();
    accept(1);

    // Range boundary: Px equal to prime, then one below
    rand_lanes();
    v[2] = 256'h17; v[3] = 256'h17; v[4] = 256'h5; v[6] = 256'h3; v[7] = 256'h0;
    load(2'b00, 3, -1, -1, -1);
    check_bundle();
    accept(1);
    v[3] = 256'h16;
    load(2'b00, 3, -1, -1, -1);
    check_bundle();
    accept(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
